// File: rtl/imem_load_ctrl_if.sv
// Loader word stream and single-port instruction-memory bus seen by imem_load_ctrl.
// The slave modport is the controller; master is the loader/memory side.
interface imem_load_ctrl_if #(
  parameter int AW = 10
);
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output ld_valid, ld_data, ld_last, mem_rdata,
    input  ld_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, mem_rdata,
    output ld_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory owner: clears the array, streams a program in while the core is held,
// then hands the memory to the fetch stage with NOP substitution on faulting fetches.
//
// state | meaning
// CLEAR | zero one word per cycle, addresses 0..DEPTH-1
// LOAD  | accept loader words into consecutive addresses, core held
// RUN   | memory owned by fetch, core released
module imem_load_ctrl #(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter int          BOOT_LOAD = 1,
  parameter int          CLEAR_EN  = 1,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req_i,
  input  logic [31:0]   if_pc_i,
  output logic [31:0]   if_instr_o,
  output logic          if_fault_o,
  output logic          core_hold_o,
  output logic [AW:0]   load_count_o,
  output logic          ld_overflow_o,
  imem_load_ctrl_if.slave bus
);

  localparam logic [1:0]  S_CLEAR = 2'd0;
  localparam logic [1:0]  S_LOAD  = 2'd1;
  localparam logic [1:0]  S_RUN   = 2'd2;
  localparam logic [1:0]  S_RESET = (CLEAR_EN != 0) ? S_CLEAR :
                                    ((BOOT_LOAD != 0) ? S_LOAD : S_RUN);
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [AW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        reload_q, reload_d;
  logic        we_c, ready_c, hold_c;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    count_d        = count_q;
    ovf_d          = ovf_q;
    reload_d       = reload_q;
    we_c           = 1'b0;
    ready_c        = 1'b0;
    hold_c         = 1'b1;
    bus.mem_addr   = if_pc_i[AW+1:2];
    bus.mem_wdata  = 32'h0;
    if_fault_o     = 1'b0;
    if_instr_o     = NOP_WORD;
    case (state_q)
      S_CLEAR: begin
        we_c         = 1'b1;
        bus.mem_addr = ptr_q[AW-1:0];
        ptr_d        = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          ptr_d    = '0;
          reload_d = 1'b0;
          // A clear started by load_req always continues into a load.
          if ((BOOT_LOAD != 0) || reload_q) begin
            state_d = S_LOAD;
            count_d = '0;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_LOAD: begin
        ready_c       = 1'b1;
        bus.mem_addr  = ptr_q[AW-1:0];
        bus.mem_wdata = bus.ld_data;
        we_c          = bus.ld_valid;
        if (bus.ld_valid) begin
          ptr_d   = ptr_q + 1'b1;
          count_d = ptr_q + 1'b1;
          if (bus.ld_last) begin
            state_d = S_RUN;
            ptr_d   = '0;
          end else if (ptr_q == LAST) begin
            ovf_d   = 1'b1;
            state_d = S_RUN;
            ptr_d   = '0;
          end
        end
      end
      S_RUN: begin
        hold_c     = 1'b0;
        if_fault_o = (if_pc_i[1:0] != 2'b00) || (if_pc_i[31:2] >= DEPTH_W);
        if_instr_o = if_fault_o ? NOP_WORD : bus.mem_rdata;
        if (load_req_i) begin
          ptr_d = '0;
          if (CLEAR_EN != 0) begin
            state_d  = S_CLEAR;
            reload_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            count_d = '0;
          end
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // Reset overrides the state decode so the memory is never written while rst_n is low.
  assign bus.mem_we    = we_c & rst_n;
  assign bus.ld_ready  = ready_c & rst_n;
  assign core_hold_o   = hold_c | ~rst_n;
  assign load_count_o  = count_q;
  assign ld_overflow_o = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      ptr_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: a default instance (clear + boot load) and a small instance
// without clear that boots straight into RUN on preset memory contents.
module tb_imem_load_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        load_req_a, load_req_b;
  logic [31:0] if_pc_a, if_pc_b;
  logic [31:0] if_instr_a, if_instr_b;
  logic        if_fault_a, if_fault_b;
  logic        core_hold_a, core_hold_b;
  logic [10:0] load_count_a;
  logic [4:0]  load_count_b;
  logic        ld_overflow_a, ld_overflow_b;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:15];
  logic [31:0] prog  [0:20];

  wr_t q_a[$];
  wr_t q_b[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  imem_load_ctrl_if #(.AW(10)) bus_a ();
  imem_load_ctrl_if #(.AW(4))  bus_b ();

  imem_load_ctrl u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_req_i    (load_req_a),
    .if_pc_i       (if_pc_a),
    .if_instr_o    (if_instr_a),
    .if_fault_o    (if_fault_a),
    .core_hold_o   (core_hold_a),
    .load_count_o  (load_count_a),
    .ld_overflow_o (ld_overflow_a),
    .bus           (bus_a.slave)
  );

  imem_load_ctrl #(.DEPTH(16), .AW(4), .BOOT_LOAD(0), .CLEAR_EN(0)) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_req_i    (load_req_b),
    .if_pc_i       (if_pc_b),
    .if_instr_o    (if_instr_b),
    .if_fault_o    (if_fault_b),
    .core_hold_o   (core_hold_b),
    .load_count_o  (load_count_b),
    .ld_overflow_o (ld_overflow_b),
    .bus           (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];
  assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];

  initial begin
    forever begin
      @(posedge clk);
      if (bus_a.mem_we === 1'b1) mem_a[bus_a.mem_addr] = bus_a.mem_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_b[i] = 32'hB000_0000 + i;
    forever begin
      @(posedge clk);
      if (bus_b.mem_we === 1'b1) mem_b[bus_b.mem_addr] = bus_b.mem_wdata;
    end
  end

  always @(negedge clk) begin : mon_a
    wr_t e;
    if (bus_a.mem_we !== 1'b0) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_write_unexpected addr=%0d data=%h required=no write", bus_a.mem_addr, bus_a.mem_wdata);
      end else begin
        e = q_a.pop_front();
        if (bus_a.mem_addr !== 10'(e.addr) || bus_a.mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL a_write addr=%0d data=%h required addr=%0d data=%h", bus_a.mem_addr, bus_a.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    if (bus_b.mem_we !== 1'b0) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_write_unexpected addr=%0d data=%h required=no write", bus_b.mem_addr, bus_b.mem_wdata);
      end else begin
        e = q_b.pop_front();
        if (bus_b.mem_addr !== 4'(e.addr) || bus_b.mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL b_write addr=%0d data=%h required addr=%0d data=%h", bus_b.mem_addr, bus_b.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear_a(input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = i;
      e.data = 32'h0;
      q_a.push_back(e);
    end
  endtask

  task automatic wait_ready_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus_a.ld_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (core_hold_a !== 1'b1 || bus_a.mem_we !== 1'b0 || bus_a.ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a_outputs hold=%b we=%b ready=%b required 1 0 0", core_hold_a, bus_a.mem_we, bus_a.ld_ready);
    end
    n_checks++;
    if (load_count_a !== 11'd0 || ld_overflow_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a_counters count=%0d ovf=%b required 0 0", load_count_a, ld_overflow_a);
    end
    n_checks++;
    if (core_hold_b !== 1'b1 || bus_b.mem_we !== 1'b0 || bus_b.ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b_outputs hold=%b we=%b ready=%b required 1 0 0", core_hold_b, bus_b.mem_we, bus_b.ld_ready);
    end
  endtask

  task automatic test_clear_abort();
    bit ok;
    push_clear_a(500);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_a.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_we_drop we=%b required 0", bus_a.mem_we);
    end
    n_checks++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL abort_write_count pending=%0d required 0", q_a.size());
    end
    repeat (2) @(posedge clk);
    push_clear_a(1024);
    #1 rst_n = 1'b1;
    wait_ready_a(1100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL clear_timeout ld_ready=%b required 1 within 1100 cycles", bus_a.ld_ready);
    end
    n_checks++;
    if (q_a.size() != 0 || core_hold_a !== 1'b1 || load_count_a !== 11'd0) begin
      n_fail++;
      $display("FAIL clear_done pending=%0d hold=%b count=%0d required 0 1 0", q_a.size(), core_hold_a, load_count_a);
    end
  endtask

  task automatic test_load_program();
    wr_t e;
    for (int i = 0; i < 21; i++) begin
      if (i == 5 || i == 11 || i == 17) begin
        bus_a.ld_valid = 1'b0;
        tick();
      end
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = prog[i];
      bus_a.ld_last  = (i == 20);
      e.addr = i;
      e.data = prog[i];
      q_a.push_back(e);
      tick();
    end
    bus_a.ld_valid = 1'b0;
    bus_a.ld_last  = 1'b0;
    n_checks++;
    if (core_hold_a !== 1'b0 || bus_a.ld_ready !== 1'b0 || load_count_a !== 11'd21) begin
      n_fail++;
      $display("FAIL load_done hold=%b ready=%b count=%0d required 0 0 21", core_hold_a, bus_a.ld_ready, load_count_a);
    end
    n_checks++;
    if (q_a.size() != 0 || ld_overflow_a !== 1'b0) begin
      n_fail++;
      $display("FAIL load_writes pending=%0d ovf=%b required 0 0", q_a.size(), ld_overflow_a);
    end
  endtask

  task automatic test_fetch();
    if_pc_a = 32'h18;
    #1;
    n_checks++;
    if (if_instr_a !== prog[6] || if_fault_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_word6 instr=%h fault=%b required %h 0", if_instr_a, if_fault_a, prog[6]);
    end
    if_pc_a = 32'h1A;
    #1;
    n_checks++;
    if (if_instr_a !== NOP || if_fault_a !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_misaligned instr=%h fault=%b required %h 1", if_instr_a, if_fault_a, NOP);
    end
    if_pc_a = 32'h1000;
    #1;
    n_checks++;
    if (if_instr_a !== NOP || if_fault_a !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_out_of_range instr=%h fault=%b required %h 1", if_instr_a, if_fault_a, NOP);
    end
    if_pc_a = 32'hFFC;
    #1;
    n_checks++;
    if (if_instr_a !== 32'h0 || if_fault_a !== 1'b0 || bus_a.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_last_word instr=%h fault=%b we=%b required 0 0 0", if_instr_a, if_fault_a, bus_a.mem_we);
    end
  endtask

  task automatic test_reload();
    bit ok;
    if_pc_a    = 32'h18;
    load_req_a = 1'b1;
    #1;
    n_checks++;
    if (if_instr_a !== prog[6] || core_hold_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_req_cycle instr=%h hold=%b required %h 0", if_instr_a, core_hold_a, prog[6]);
    end
    push_clear_a(1024);
    tick();
    load_req_a = 1'b0;
    n_checks++;
    if (core_hold_a !== 1'b1 || bus_a.ld_ready !== 1'b0 || if_instr_a !== NOP) begin
      n_fail++;
      $display("FAIL reload_clear_entry hold=%b ready=%b instr=%h required 1 0 %h", core_hold_a, bus_a.ld_ready, if_instr_a, NOP);
    end
    wait_ready_a(1100, ok);
    n_checks++;
    if (!ok || q_a.size() != 0 || load_count_a !== 11'd0) begin
      n_fail++;
      $display("FAIL reload_to_load ready=%b pending=%0d count=%0d required 1 0 0", bus_a.ld_ready, q_a.size(), load_count_a);
    end
    load_req_a = 1'b1;
    tick();
    load_req_a = 1'b0;
    tick();
    n_checks++;
    if (bus_a.ld_ready !== 1'b1 || core_hold_a !== 1'b1) begin
      n_fail++;
      $display("FAIL load_req_in_load ready=%b hold=%b required 1 1", bus_a.ld_ready, core_hold_a);
    end
  endtask

  task automatic test_overflow();
    wr_t e;
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = 32'h5A00_0000 ^ (i * 32'h0001_0003);
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = w;
      bus_a.ld_last  = 1'b0;
      e.addr = i;
      e.data = w;
      q_a.push_back(e);
      tick();
      if (i == 1022) begin
        n_checks++;
        if (ld_overflow_a !== 1'b0 || bus_a.ld_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL overflow_early ovf=%b ready=%b required 0 1", ld_overflow_a, bus_a.ld_ready);
        end
      end
    end
    n_checks++;
    if (ld_overflow_a !== 1'b1 || core_hold_a !== 1'b0 || bus_a.ld_ready !== 1'b0 || load_count_a !== 11'd1024) begin
      n_fail++;
      $display("FAIL overflow_done ovf=%b hold=%b ready=%b count=%0d required 1 0 0 1024", ld_overflow_a, core_hold_a, bus_a.ld_ready, load_count_a);
    end
    repeat (2) tick();
    bus_a.ld_valid = 1'b0;
    n_checks++;
    if (bus_a.ld_ready !== 1'b0 || load_count_a !== 11'd1024 || ld_overflow_a !== 1'b1 || q_a.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_after ready=%b count=%0d ovf=%b pending=%0d required 0 1024 1 0", bus_a.ld_ready, load_count_a, ld_overflow_a, q_a.size());
    end
    if_pc_a = 32'hFFC;
    #1;
    w = 32'h5A00_0000 ^ (1023 * 32'h0001_0003);
    n_checks++;
    if (if_instr_a !== w || if_fault_a !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_fetch_last instr=%h fault=%b required %h 0", if_instr_a, if_fault_a, w);
    end
  endtask

  task automatic test_no_clear();
    wr_t e;
    logic [31:0] wb [0:2];
    wb[0] = 32'h1111_0001;
    wb[1] = 32'h2222_0002;
    wb[2] = 32'h3333_0003;
    if_pc_b = 32'h8;
    #1;
    n_checks++;
    if (core_hold_b !== 1'b0 || if_instr_b !== 32'hB000_0002 || if_fault_b !== 1'b0) begin
      n_fail++;
      $display("FAIL b_boot_run hold=%b instr=%h fault=%b required 0 b0000002 0", core_hold_b, if_instr_b, if_fault_b);
    end
    if_pc_b = 32'h40;
    #1;
    n_checks++;
    if (if_instr_b !== NOP || if_fault_b !== 1'b1) begin
      n_fail++;
      $display("FAIL b_out_of_range instr=%h fault=%b required %h 1", if_instr_b, if_fault_b, NOP);
    end
    if_pc_b    = 32'h3D;
    load_req_b = 1'b1;
    tick();
    load_req_b = 1'b0;
    n_checks++;
    if (core_hold_b !== 1'b1 || bus_b.ld_ready !== 1'b1 || if_fault_b !== 1'b0 || if_instr_b !== NOP || load_count_b !== 5'd0) begin
      n_fail++;
      $display("FAIL b_load_entry hold=%b ready=%b fault=%b instr=%h count=%0d required 1 1 0 %h 0", core_hold_b, bus_b.ld_ready, if_fault_b, if_instr_b, load_count_b, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      bus_b.ld_valid = 1'b1;
      bus_b.ld_data  = wb[i];
      bus_b.ld_last  = (i == 2);
      e.addr = i;
      e.data = wb[i];
      q_b.push_back(e);
      tick();
    end
    bus_b.ld_valid = 1'b0;
    bus_b.ld_last  = 1'b0;
    n_checks++;
    if (core_hold_b !== 1'b0 || load_count_b !== 5'd3 || ld_overflow_b !== 1'b0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL b_load_done hold=%b count=%0d ovf=%b pending=%0d required 0 3 0 0", core_hold_b, load_count_b, ld_overflow_b, q_b.size());
    end
    if_pc_b = 32'h4;
    #1;
    n_checks++;
    if (if_instr_b !== wb[1]) begin
      n_fail++;
      $display("FAIL b_fetch_loaded instr=%h required %h", if_instr_b, wb[1]);
    end
    if_pc_b = 32'h3C;
    #1;
    n_checks++;
    if (if_instr_b !== 32'hB000_000F) begin
      n_fail++;
      $display("FAIL b_fetch_preset instr=%h required b000000f", if_instr_b);
    end
  endtask

  initial begin
    prog[0]  = 32'h00A0_0293;
    prog[1]  = 32'h0000_0313;
    for (int i = 2; i < 20; i++) prog[i] = 32'h0013_0313 + (i << 20);
    prog[20] = 32'hFA00_0AE3;

    rst_n          = 1'b0;
    load_req_a     = 1'b0;
    load_req_b     = 1'b0;
    if_pc_a        = 32'h0;
    if_pc_b        = 32'h0;
    bus_a.ld_valid = 1'b0;
    bus_a.ld_data  = 32'h0;
    bus_a.ld_last  = 1'b0;
    bus_b.ld_valid = 1'b0;
    bus_b.ld_data  = 32'h0;
    bus_b.ld_last  = 1'b0;
    #2;

    test_reset();
    test_clear_abort();
    test_load_program();
    test_fetch();
    test_reload();
    test_overflow();
    test_no_clear();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
